clic_gateway: RTL and testbench
===============================

CLIC_GATEWAY -- requirements
Module: clic_gateway

Interface
REQ-001 SHALL have parameter N_SOURCE, default 256, meaning number of interrupt sources; legal range 2 or more.
REQ-002 SHALL have parameter SyncStages, default 2, meaning synchronizer depth on src_i; legal range 0..3; 0 means no synchronizer.
REQ-003 SHALL have port clk_i  input  1  meaning the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  meaning reset, synchronous and active-low.
REQ-005 SHALL have port src_i  input  N_SOURCE  meaning raw asynchronous interrupt lines, one bit per source.
REQ-006 SHALL have port trig_edge_i  input  N_SOURCE  meaning trigger type per source: 1 = edge-triggered, 0 = level-triggered.
REQ-007 SHALL have port trig_neg_i  input  N_SOURCE  meaning polarity per source: 0 = active-high or rising edge, 1 = active-low or falling edge.
REQ-008 SHALL have port sw_set_i  input  N_SOURCE  meaning single-cycle software set-pending strobes.
REQ-009 SHALL have port sw_clr_i  input  N_SOURCE  meaning single-cycle software clear-pending strobes.
REQ-010 SHALL have port claim_i  input  N_SOURCE  meaning single-cycle claim pulses from the downstream arbiter stage.
REQ-011 SHALL have port ip_o  output  N_SOURCE  meaning registered pending bits, which feed the arbiter ip input.
REQ-012 SHALL have port le_o  output  N_SOURCE  meaning edge-enable per source, which feeds the arbiter le input.

Function
REQ-013 SHALL delay src_i through a chain of SyncStages flops per bit to produce src_s; with SyncStages = 0, src_s SHALL equal src_i.
REQ-014 SHALL hold a register src_prev that is src_s delayed by 1 cycle.
REQ-015 SHALL compute the edge as: rising = src_s & ~src_prev when trig_neg_i = 0; falling = ~src_s & src_prev when trig_neg_i = 1.
REQ-016 SHALL compute active = src_s XOR trig_neg_i.
REQ-017 In edge mode (trig_edge_i = 1), the next value of ip SHALL be (ip & ~(claim_i | sw_clr_i)) | edge | sw_set_i; a set event (edge or sw_set_i) SHALL win over a clear event (claim_i or sw_clr_i) arriving in the same cycle.
REQ-018 In level mode (trig_edge_i = 0), the next value of ip SHALL equal active; sw_set_i, sw_clr_i and claim_i SHALL be ignored.
REQ-019 Edge latency: a src_i transition sampled at rising edge t SHALL appear on ip_o after rising edge t + SyncStages + 1.
REQ-020 Level latency: same as edge latency, t + SyncStages + 1; deassertion SHALL follow with equal latency.
REQ-021 sw_set_i, sw_clr_i and claim_i SHALL affect ip_o after exactly 1 rising edge.
REQ-022 Level-to-edge switch of trig_edge_i: ip SHALL retain its current value, then follow REQ-017.
REQ-023 Edge-to-level switch of trig_edge_i: ip SHALL take active on the next edge.
REQ-024 A held edge-mode source SHALL generate exactly one edge; while the line stays asserted, no re-pend SHALL occur after a claim.
REQ-025 Multiple edges before a claim SHALL collapse into one pending bit; there is no counting.
REQ-026 Polarity change while in edge mode SHALL NOT itself create an edge unless src_s and src_prev differ in the new sense.
REQ-027 le_o SHALL equal trig_edge_i combinationally, with zero latency.
REQ-028 Each source bit SHALL be fully independent; there SHALL be no cross-source interaction.
REQ-029 claim_i asserted for a source that is not pending SHALL have no effect.

Reset
REQ-030 While rst_ni = 0 at a rising edge, all synchronizer flops, src_prev and ip SHALL be set to 0.
REQ-031 ip_o SHALL be all-zero from the first rising edge with rst_ni = 0 until at least SyncStages + 1 edges after reset release.
REQ-032 Reset asserted mid-operation SHALL discard pending bits and in-flight synchronizer data within that same edge.
REQ-033 After reset release, a source already high with rising-edge configuration SHALL produce one edge; a source already low with falling-edge configuration SHALL NOT.

Verification (N_SOURCE = 4, SyncStages = 2)
REQ-034 Setup: src 0 edge, rising. Stimulus: src_i[0] goes 0 to 1 at edge t and is held. Response: ip_o[0] = 1 from t+3; claim_i[0] at t+5 gives ip_o[0] = 0 at t+6, and it stays 0.
REQ-035 Setup: src 1 level, trig_neg_i[1] = 1. Stimulus: src_i[1] low from t to t+4. Response: ip_o[1] = 1 from t+3; ip_o[1] = 0 three edges after src_i[1] returns high; sw_clr_i[1] has no effect.
REQ-036 Setup: src 2 edge, pending. Stimulus: claim_i[2] and sw_set_i[2] in the same cycle. Response: ip_o[2] stays 1; sw_clr_i[2] alone then clears it after 1 edge.
REQ-037 Setup: src 3 edge, falling. Stimulus: src_i[3] pulses 1, 0, 1, 0 with no claim. Response: ip_o[3] = 1 exactly once and stays 1 until cleared.
REQ-038 Setup: ip_o = 4'b1111. Stimulus: rst_ni = 0 for 1 edge while src_i = 4'b0001, all edge and rising. Response: ip_o = 4'b0000 at that edge; ip_o[0] = 1 three edges after release.

Source files
------------

// File: rtl/clic_gateway.sv
// Interrupt gateway: synchronizes raw source lines and turns them into per-source
// pending bits, either edge-latched (with software set/clear and claim) or level-following.
module clic_gateway #(
    parameter int N_SOURCE   = 256,
    parameter int SyncStages = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_SOURCE-1:0] src_i,
    input  logic [N_SOURCE-1:0] trig_edge_i,
    input  logic [N_SOURCE-1:0] trig_neg_i,
    input  logic [N_SOURCE-1:0] sw_set_i,
    input  logic [N_SOURCE-1:0] sw_clr_i,
    input  logic [N_SOURCE-1:0] claim_i,
    output logic [N_SOURCE-1:0] ip_o,
    output logic [N_SOURCE-1:0] le_o
);

    logic [N_SOURCE-1:0] w_src_s;
    logic [N_SOURCE-1:0] r_src_prev;
    logic [N_SOURCE-1:0] r_ip;
    logic [N_SOURCE-1:0] w_edge;
    logic [N_SOURCE-1:0] w_active;
    logic [N_SOURCE-1:0] w_ip_next;

    generate
        if (SyncStages == 0) begin : g_nosync
            assign w_src_s = src_i;
        end else begin : g_sync
            logic [N_SOURCE-1:0] r_sync [SyncStages];

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    for (int i = 0; i < SyncStages; i++) begin
                        r_sync[i] <= '0;
                    end
                end else begin
                    r_sync[0] <= src_i;
                    for (int i = 1; i < SyncStages; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_src_s = r_sync[SyncStages-1];
        end
    endgenerate

    // Polarity selects which transition of the synchronized line counts as an edge.
    assign w_edge   = (~trig_neg_i &  w_src_s & ~r_src_prev)
                    | ( trig_neg_i & ~w_src_s &  r_src_prev);
    assign w_active = w_src_s ^ trig_neg_i;

    genvar gi;
    generate
        for (gi = 0; gi < N_SOURCE; gi++) begin : g_src
            // Set terms are OR'ed after the clear mask so a same-cycle set wins.
            assign w_ip_next[gi] = trig_edge_i[gi]
                ? ((r_ip[gi] & ~(claim_i[gi] | sw_clr_i[gi])) | w_edge[gi] | sw_set_i[gi])
                : w_active[gi];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_src_prev <= '0;
            r_ip       <= '0;
        end else begin
            r_src_prev <= w_src_s;
            r_ip       <= w_ip_next;
        end
    end

    assign ip_o = r_ip;
    assign le_o = trig_edge_i;

endmodule

// File: tb/tb_clic_gateway.sv
// Directed bench for clic_gateway (4 sources, 2 sync stages): latency, edge/level
// behaviour, set-over-clear priority, mode switches and mid-run reset.
module tb_clic_gateway;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [3:0] src_i, trig_edge_i, trig_neg_i, sw_set_i, sw_clr_i, claim_i;
    logic [3:0] ip_o, le_o;

    int tests = 0;
    int fails = 0;

    clic_gateway #(.N_SOURCE(4), .SyncStages(2)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .src_i       (src_i),
        .trig_edge_i (trig_edge_i),
        .trig_neg_i  (trig_neg_i),
        .sw_set_i    (sw_set_i),
        .sw_clr_i    (sw_clr_i),
        .claim_i     (claim_i),
        .ip_o        (ip_o),
        .le_o        (le_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
        $display("[TB] %s: observed %b expected %b", tag, obs, exp);
    endtask

    initial begin
        rst_ni      = 1'b0;
        src_i       = 4'b1010;
        trig_edge_i = 4'b1101;
        trig_neg_i  = 4'b1010;
        sw_set_i    = '0;
        sw_clr_i    = '0;
        claim_i     = '0;
        tick(2);
        check("reset_ip", ip_o, 4'b0000);
        check("le_follows_trig_edge", le_o, 4'b1101);
        rst_ni = 1'b1;
        tick(4);
        check("idle_after_release", ip_o, 4'b0000);

        // Source 0: rising edge, held high, claimed once.
        src_i[0] = 1'b1;
        tick(2);
        check("edge0_not_yet", ip_o, 4'b0000);
        tick(1);
        check("edge0_latency", ip_o, 4'b0001);
        tick(1);
        check("edge0_held", ip_o, 4'b0001);
        claim_i[0] = 1'b1;
        tick(1);
        claim_i[0] = 1'b0;
        check("edge0_claimed", ip_o, 4'b0000);
        tick(4);
        check("edge0_no_repend", ip_o, 4'b0000);

        // Source 1: active-low level; software clear ignored.
        src_i[1] = 1'b0;
        tick(2);
        check("lvl1_not_yet", ip_o, 4'b0000);
        tick(1);
        check("lvl1_assert", ip_o, 4'b0010);
        sw_clr_i[1] = 1'b1;
        tick(1);
        sw_clr_i[1] = 1'b0;
        check("lvl1_swclr_ignored", ip_o, 4'b0010);
        src_i[1] = 1'b1;
        tick(2);
        check("lvl1_deassert_pending", ip_o, 4'b0010);
        tick(1);
        check("lvl1_deassert", ip_o, 4'b0000);

        // Source 2: set wins over same-cycle claim; then plain clear.
        sw_set_i[2] = 1'b1;
        tick(1);
        sw_set_i[2] = 1'b0;
        check("sw_set2", ip_o, 4'b0100);
        claim_i[2]  = 1'b1;
        sw_set_i[2] = 1'b1;
        tick(1);
        claim_i[2]  = 1'b0;
        sw_set_i[2] = 1'b0;
        check("set_beats_claim2", ip_o, 4'b0100);
        sw_clr_i[2] = 1'b1;
        tick(1);
        sw_clr_i[2] = 1'b0;
        check("sw_clr2", ip_o, 4'b0000);
        claim_i[2] = 1'b1;
        tick(1);
        claim_i[2] = 1'b0;
        check("claim_not_pending2", ip_o, 4'b0000);

        // Source 3: falling edges collapse into a single pending bit.
        src_i[3] = 1'b0;
        tick(2);
        check("fall3_not_yet", ip_o, 4'b0000);
        tick(1);
        check("fall3_latency", ip_o, 4'b1000);
        src_i[3] = 1'b1;
        tick(2);
        src_i[3] = 1'b0;
        tick(4);
        check("fall3_collapsed", ip_o, 4'b1000);
        claim_i[3] = 1'b1;
        tick(1);
        claim_i[3] = 1'b0;
        check("fall3_claimed", ip_o, 4'b0000);
        tick(4);
        check("fall3_no_repend", ip_o, 4'b0000);

        // Source 1: level-to-edge keeps ip, edge-to-level resamples active.
        src_i[1] = 1'b0;
        tick(3);
        check("sw1_level_pending", ip_o, 4'b0010);
        trig_edge_i[1] = 1'b1;
        #1;
        check("le_zero_latency", le_o, 4'b1111);
        tick(1);
        check("sw1_retain_after_switch", ip_o, 4'b0010);
        claim_i[1] = 1'b1;
        tick(1);
        claim_i[1] = 1'b0;
        check("sw1_edge_claimed", ip_o, 4'b0000);
        trig_edge_i[1] = 1'b0;
        tick(1);
        check("sw1_back_to_level", ip_o, 4'b0010);
        src_i[1] = 1'b1;
        tick(3);
        check("sw1_level_released", ip_o, 4'b0000);

        // Reset mid-run with everything pending.
        trig_edge_i = 4'b1111;
        trig_neg_i  = 4'b0000;
        src_i       = 4'b0001;
        tick(1);
        check("cfg_change_no_edge", ip_o, 4'b0000);
        sw_set_i = 4'b1111;
        tick(1);
        sw_set_i = 4'b0000;
        check("all_pending", ip_o, 4'b1111);
        rst_ni = 1'b0;
        tick(1);
        check("reset_clears_same_edge", ip_o, 4'b0000);
        rst_ni = 1'b1;
        tick(2);
        check("post_reset_not_yet", ip_o, 4'b0000);
        tick(1);
        check("post_reset_edge0", ip_o, 4'b0001);

        // Polarity flip on a steady line must not create an edge.
        claim_i[0] = 1'b1;
        tick(1);
        claim_i[0] = 1'b0;
        check("pol0_claimed", ip_o, 4'b0000);
        trig_neg_i[0] = 1'b1;
        tick(3);
        check("pol_flip_no_edge", ip_o, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
